// File: rtl/coin_start_sequencer_if.sv
// coin_start_sequencer_if: control inputs and core-side coin/start outputs of the sequencer
interface coin_start_sequencer_if;
    logic tick;
    logic auto_coin;
    logic req_start1;
    logic req_start2;
    logic coin_in;
    logic coin_out;
    logic start1_out;
    logic start2_out;
    logic busy;
    modport master (
        output tick, auto_coin, req_start1, req_start2, coin_in,
        input  coin_out, start1_out, start2_out, busy
    );
    modport slave (
        input  tick, auto_coin, req_start1, req_start2, coin_in,
        output coin_out, start1_out, start2_out, busy
    );
endinterface

// File: rtl/coin_start_sequencer.sv
// coin_start_sequencer: turns one start press into a timed coin pulse, gap and start pulse
module coin_start_sequencer #(
    parameter int COIN_TICKS  = 4,
    parameter int GAP_TICKS   = 4,
    parameter int START_TICKS = 4
) (
    input logic clk_sys,
    input logic reset,
    coin_start_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, COIN, GAP, START, RELEASE} state_t;
    state_t state, state_nxt;
    logic [7:0] cnt, cnt_nxt, lim;
    logic p2, p2_nxt, prev1, prev2, edge1, edge2;
    assign edge1 = bus.req_start1 & ~prev1;
    assign edge2 = bus.req_start2 & ~prev2;
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        p2_nxt    = p2;
        lim = state == COIN ? 8'(COIN_TICKS) : state == GAP ? 8'(GAP_TICKS) : 8'(START_TICKS);
        if (state == IDLE) begin
            if (bus.auto_coin && (edge1 || edge2)) begin
                state_nxt = COIN;
                p2_nxt    = ~edge1;
            end
        end else if (state == RELEASE) begin
            if (!bus.req_start1 && !bus.req_start2) state_nxt = IDLE;
        end else if (bus.tick) begin
            if (cnt == lim - 8'd1)
                state_nxt = state == COIN ? GAP : state == GAP ? START : RELEASE;
            else
                cnt_nxt = cnt + 8'd1;
        end
        if (!bus.auto_coin) state_nxt = IDLE;
        if (state_nxt != state || !bus.auto_coin) cnt_nxt = 8'd0;
    end
    // outputs are registered from the next state so a sequence shows up one cycle after the edge
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= 8'd0;
            p2             <= 1'b0;
            prev1          <= 1'b1;
            prev2          <= 1'b1;
            bus.coin_out   <= 1'b0;
            bus.start1_out <= 1'b0;
            bus.start2_out <= 1'b0;
            bus.busy       <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            p2             <= p2_nxt;
            prev1          <= bus.req_start1;
            prev2          <= bus.req_start2;
            bus.coin_out   <= bus.coin_in | (state_nxt == COIN);
            bus.start1_out <= (state_nxt == START && !p2_nxt) || (!bus.auto_coin && bus.req_start1);
            bus.start2_out <= (state_nxt == START && p2_nxt) || (!bus.auto_coin && bus.req_start2);
            bus.busy       <= state_nxt != IDLE;
        end
    end
endmodule

// File: tb/tb_coin_start_sequencer.sv
// tb_coin_start_sequencer: scoreboard bench measuring per-sequence tick counts plus cycle checks
module tb_coin_start_sequencer;
    logic clk_sys = 1'b0;
    logic reset = 1'b1;
    logic tick_en = 1'b1;
    int n_checks = 0;
    int n_fail = 0;
    typedef struct {int coin; int gap; int s1; int s2;} seq_t;
    seq_t exp_q[$];
    always #5 clk_sys = ~clk_sys;
    coin_start_sequencer_if bus();
    coin_start_sequencer dut (.clk_sys(clk_sys), .reset(reset), .bus(bus));
    initial begin
        bus.tick = 1'b0;
        forever begin
            repeat (9) @(posedge clk_sys);
            #1 bus.tick = tick_en;
            @(posedge clk_sys);
            #1 bus.tick = 1'b0;
        end
    end
    int phase, c_coin, c_gap, c_s1, c_s2;
    logic prev_busy = 1'b0;
    seq_t e;
    // measures each sequence from busy rise to busy fall and scores it against the queue
    always @(negedge clk_sys) begin
        if (bus.busy && !prev_busy) begin
            phase = 0; c_coin = 0; c_gap = 0; c_s1 = 0; c_s2 = 0;
        end
        if (bus.busy) begin
            if (phase == 0 && !bus.coin_out) phase = 1;
            if (phase == 1 && (bus.start1_out || bus.start2_out)) phase = 2;
            if (phase == 2 && !(bus.start1_out || bus.start2_out)) phase = 3;
            if (bus.tick) begin
                if (phase == 0 && bus.coin_out) c_coin++;
                if (phase == 1) c_gap++;
                if (phase == 2 && bus.start1_out) c_s1++;
                if (phase == 2 && bus.start2_out) c_s2++;
            end
        end
        if (!bus.busy && prev_busy) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_seq: got a sequence, expected none");
            end else begin
                e = exp_q.pop_front();
                n_checks += 4;
                if (c_coin !== e.coin) begin n_fail++; $display("FAIL coin_ticks: got %0d expected %0d", c_coin, e.coin); end
                if (c_gap !== e.gap) begin n_fail++; $display("FAIL gap_ticks: got %0d expected %0d", c_gap, e.gap); end
                if (c_s1 !== e.s1) begin n_fail++; $display("FAIL start1_ticks: got %0d expected %0d", c_s1, e.s1); end
                if (c_s2 !== e.s2) begin n_fail++; $display("FAIL start2_ticks: got %0d expected %0d", c_s2, e.s2); end
            end
        end
        prev_busy = bus.busy;
    end
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask
    task automatic wait_idle();
        int i;
        for (i = 0; i < 400 && bus.busy; i++) cyc(1);
        n_checks++;
        if (bus.busy) begin n_fail++; $display("FAIL idle_timeout: got busy=1 expected 0"); end
        cyc(3);
    endtask
    task automatic test_reset();
        bus.auto_coin = 1'b1; bus.req_start1 = 1'b1; bus.req_start2 = 1'b0; bus.coin_in = 1'b0;
        reset = 1'b1;
        cyc(3);
        n_checks += 4;
        if (bus.coin_out !== 1'b0) begin n_fail++; $display("FAIL reset_coin: got %b expected 0", bus.coin_out); end
        if (bus.start1_out !== 1'b0) begin n_fail++; $display("FAIL reset_start1: got %b expected 0", bus.start1_out); end
        if (bus.start2_out !== 1'b0) begin n_fail++; $display("FAIL reset_start2: got %b expected 0", bus.start2_out); end
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            n_checks++;
            if (bus.busy !== 1'b0 || bus.coin_out !== 1'b0) begin
                n_fail++; $display("FAIL held_through_reset: got busy=%b coin=%b expected 0 0", bus.busy, bus.coin_out);
            end
        end
        bus.req_start1 = 1'b0;
        cyc(2);
        exp_q.push_back('{4, 4, 4, 0});
        bus.req_start1 = 1'b1;
        cyc(1);
        n_checks++;
        if (bus.coin_out !== 1'b1 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL start_latency: got coin=%b busy=%b expected 1 1", bus.coin_out, bus.busy);
        end
        bus.req_start1 = 1'b0;
        wait_idle();
    endtask
    task automatic test_basic();
        int i;
        exp_q.push_back('{4, 4, 4, 0});
        bus.req_start1 = 1'b1;
        cyc(3);
        bus.req_start1 = 1'b0;
        for (i = 0; i < 400 && !bus.start1_out; i++) cyc(1);
        for (i = 0; i < 400 && bus.start1_out; i++) cyc(1);
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_start: got %b expected 1", bus.busy); end
        cyc(1);
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL busy_fall: got %b expected 0", bus.busy); end
        wait_idle();
    endtask
    task automatic test_both_edges();
        int i;
        exp_q.push_back('{4, 4, 4, 0});
        bus.req_start1 = 1'b1; bus.req_start2 = 1'b1;
        cyc(1);
        bus.req_start1 = 1'b0; bus.req_start2 = 1'b0;
        n_checks++;
        if (bus.coin_out !== 1'b1) begin n_fail++; $display("FAIL both_edges_coin: got %b expected 1", bus.coin_out); end
        for (i = 0; i < 400 && bus.coin_out; i++) cyc(1);
        cyc(2);
        bus.req_start2 = 1'b1;
        cyc(3);
        bus.req_start2 = 1'b0;
        wait_idle();
        cyc(60);
        n_checks++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL both_edges_queue: got %0d pending expected 0", exp_q.size()); end
    endtask
    task automatic test_release_hold();
        int i;
        exp_q.push_back('{4, 4, 0, 4});
        bus.req_start2 = 1'b1;
        for (i = 0; i < 400 && !bus.start2_out; i++) cyc(1);
        for (i = 0; i < 400 && bus.start2_out; i++) cyc(1);
        cyc(20);
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL release_hold_busy: got %b expected 1", bus.busy); end
        bus.req_start2 = 1'b0;
        cyc(1);
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL release_busy_fall: got %b expected 0", bus.busy); end
        cyc(50);
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL release_retrigger: got %b expected 0", bus.busy); end
    endtask
    task automatic test_passthrough();
        int hi = 0;
        bus.auto_coin = 1'b0;
        cyc(2);
        for (int i = 0; i < 12; i++) begin
            bus.req_start1 = (i >= 2 && i < 9);
            cyc(1);
            n_checks++;
            if (bus.start1_out !== bus.req_start1 || bus.coin_out !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL passthrough: got s1=%b coin=%b busy=%b expected s1=%b coin=0 busy=0",
                         bus.start1_out, bus.coin_out, bus.busy, bus.req_start1);
            end
            if (bus.start1_out) hi++;
        end
        n_checks++;
        if (hi !== 7) begin n_fail++; $display("FAIL passthrough_width: got %0d expected 7", hi); end
        bus.auto_coin = 1'b1;
        tick_en = 1'b0;
        cyc(2);
        exp_q.push_back('{0, 0, 0, 0});
        bus.req_start1 = 1'b1;
        cyc(1);
        bus.req_start1 = 1'b0;
        cyc(2);
        bus.auto_coin = 1'b0;
        cyc(1);
        n_checks++;
        if (bus.coin_out !== 1'b0 || bus.busy !== 1'b0 || bus.start1_out !== 1'b0) begin
            n_fail++; $display("FAIL abort: got coin=%b busy=%b s1=%b expected 0 0 0", bus.coin_out, bus.busy, bus.start1_out);
        end
        bus.auto_coin = 1'b1;
        tick_en = 1'b1;
        cyc(3);
    endtask
    task automatic test_coin_in();
        int i;
        bus.coin_in = 1'b1;
        cyc(1);
        n_checks++;
        if (bus.coin_out !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL coin_idle: got coin=%b busy=%b expected 1 0", bus.coin_out, bus.busy);
        end
        bus.coin_in = 1'b0;
        cyc(1);
        n_checks++;
        if (bus.coin_out !== 1'b0) begin n_fail++; $display("FAIL coin_idle_fall: got %b expected 0", bus.coin_out); end
        exp_q.push_back('{4, 4, 4, 0});
        bus.req_start1 = 1'b1;
        cyc(2);
        bus.req_start1 = 1'b0;
        for (i = 0; i < 400 && !bus.start1_out; i++) cyc(1);
        cyc(2);
        bus.coin_in = 1'b1;
        n_checks++;
        if (bus.coin_out !== 1'b0) begin n_fail++; $display("FAIL coin_start_pre: got %b expected 0", bus.coin_out); end
        cyc(1);
        bus.coin_in = 1'b0;
        n_checks++;
        if (bus.coin_out !== 1'b1 || bus.start1_out !== 1'b1) begin
            n_fail++; $display("FAIL coin_start_follow: got coin=%b s1=%b expected 1 1", bus.coin_out, bus.start1_out);
        end
        cyc(1);
        n_checks++;
        if (bus.coin_out !== 1'b0 || bus.start1_out !== 1'b1) begin
            n_fail++; $display("FAIL coin_start_fall: got coin=%b s1=%b expected 0 1", bus.coin_out, bus.start1_out);
        end
        wait_idle();
    endtask
    initial begin
        test_reset();
        test_basic();
        test_both_edges();
        test_release_hold();
        test_passthrough();
        test_coin_in();
        n_checks++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL final_queue: got %0d pending expected 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/coin_start_sequencer.md
# coin_start_sequencer

Input-side scheduler between the merged keyboard/joystick controls and the arcade core's coin/start inputs. A single start press becomes a timed sequence: coin pulse, gap, then start pulse for the requesting player. This lets one button credit and start a game without the coin and start lines being asserted together. Runs on the system clock; the timing base is an external strobe, normally one per video frame.

## Interface
Parameters:
- COIN_TICKS, 4: ticks coin_out is held by the sequence (1..255)
- GAP_TICKS, 4: ticks between coin release and start assertion (1..255)
- START_TICKS, 4: ticks start pulse is held (1..255)

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high
- tick  in  1  timing strobe, one clk_sys cycle wide (e.g. VBlank rising edge)
- auto_coin  in  1  1 = sequence coin+start; 0 = start buttons pass through, no coin generated
- req_start1  in  1  player-1 start button, level
- req_start2  in  1  player-2 start button, level
- coin_in  in  1  dedicated coin button, level
- coin_out  out  1  to core coin input
- start1_out  out  1  to core start1
- start2_out  out  1  to core start2
- busy  out  1  sequence in progress (state ≠ IDLE)

## Operation
- All inputs are already synchronous to clk_sys.
- Rising-edge detect on req_start1/req_start2:
  - Previous-value registers reset to 1, so a button held through reset never triggers.
- State machine, 3-bit:
  - **IDLE**: on edge1 or edge2 with auto_coin=1 → COIN. Latch player = 1 if edge1, else 2. Edge1 wins when both edges occur in the same cycle.
  - **COIN**: on each tick, tick counter increments. On the tick where counter = COIN_TICKS-1 → GAP, counter cleared.
  - **GAP**: same rule with GAP_TICKS → START.
  - **START**: same rule with START_TICKS → RELEASE.
  - **RELEASE**: when req_start1=0 and req_start2=0 → IDLE. Stays in RELEASE while either is held.
- Tick counter: 8 bits, cleared on every state change and on reset. Counts only on tick=1 cycles.
- Edges arriving while busy=1 are discarded, not queued.
- auto_coin=0:
  - FSM is forced to IDLE and counter cleared.
  - start1_out = registered req_start1; start2_out = registered req_start2.
- Dropping auto_coin to 0 mid-sequence aborts it: IDLE on the next cycle, and all sequence-driven outputs fall.
- Output equations (all registered):
  - coin_out = coin_in | (state==COIN)
  - start1_out = (state==START & player==1) | (!auto_coin & req_start1)
  - start2_out = (state==START & player==2) | (!auto_coin & req_start2)
  - busy = (state≠IDLE)
- coin_in always passes through, one cycle late, in every state and mode.

## Timing
- Reset values:
  - coin_out = 0, start1_out = 0, start2_out = 0, busy = 0
  - state = IDLE, counter = 0, player = 1
  - edge registers = 1
- Reset mid-sequence: all outputs 0 on the cycle after reset is sampled. No resume.
- Start latency: request edge sampled at cycle n → coin_out=1 and busy=1 at n+1.
- coin_out stays high from n+1 through the cycle carrying the COIN_TICKS-th tick. It falls the cycle after that tick; start is not yet asserted.
- Exactly COIN_TICKS ticks are observed with coin_out=1 from the sequence. Same rule for GAP_TICKS (both outputs low) and START_TICKS (start high).
- A tick coincident with the request edge (cycle n) is not counted.
- Pass-through mode and coin_in: 1-cycle latency.

## Test plan
- Reset hold test (req_start1=1 held across reset release, auto_coin=1): no coin_out, busy stays 0. Then release and press → sequence starts.
- Default params, tick every 10 cycles, req_start1 pulse of 3 cycles:
  - coin_out high for exactly 4 ticks, then 4 ticks with both outputs low, then start1_out high for 4 ticks, start2_out never set.
  - busy falls one cycle after START ends, since the button is already released.
- Same-cycle edges on req_start1 and req_start2 → only start1_out pulses. A req_start2 press during GAP is ignored: no second sequence after IDLE.
- req_start2 still held at end of START → busy stays 1 in RELEASE until release, then 0 the next cycle. No retrigger.
- auto_coin=0: req_start1 pulse of 7 cycles → start1_out identical, delayed 1 cycle, coin_out stays 0. Clearing auto_coin during COIN → coin_out=0, busy=0 on the next cycle.
- coin_in pulse during START of a sequence → coin_out follows coin_in with 1-cycle delay, while start1_out is unaffected.
